// File: rtl/lenet_pkg.sv
// Shared LeNet engine constants and the input-loader state encoding.
package lenet_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FRAC_BITS = 16;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_SZ    = 28;
    localparam int unsigned PAD       = 2;
    localparam int unsigned INPUT_SZ  = IMG_SZ + 2 * PAD;
    localparam int unsigned ADDR_W    = 10;

    localparam int unsigned LAYER1_SZ = 28;
    localparam int unsigned LAYER2_SZ = 14;
    localparam int unsigned LAYER3_SZ = 10;
    localparam int unsigned LAYER4_SZ = 5;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_WAIT_ENG,
        LD_FILL,
        LD_FINISH
    } loader_state_t;

endpackage

// File: rtl/pad_scan_counter.sv
// Raster row/column scan over the padded plane, flagging the active interior
// window and the final scan position.
module pad_scan_counter
    import lenet_pkg::*;
#(
    parameter int unsigned SZ     = INPUT_SZ,
    parameter int unsigned BORDER = PAD,
    parameter int unsigned IMG    = IMG_SZ,
    parameter int unsigned CNT_W  = $clog2(INPUT_SZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             interior,
    output logic             last_pos
);

    localparam logic [CNT_W-1:0] LO  = CNT_W'(BORDER);
    localparam logic [CNT_W-1:0] HI  = CNT_W'(BORDER + IMG - 1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(SZ - 1);

    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] col_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance) begin
            if (col_q == MAX) begin
                col_q <= '0;
                row_q <= (row_q == MAX) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_q <= col_q + CNT_W'(1);
            end
        end
    end

    assign row      = row_q;
    assign col      = col_q;
    assign interior = (row_q >= LO) && (row_q <= HI) && (col_q >= LO) && (col_q <= HI);
    assign last_pos = (row_q == MAX) && (col_q == MAX);

endmodule

// File: rtl/input_loader.sv
// Streams a 28x28 pixel frame into the zero-padded 32x32 input SRAM plane as
// Q16.16 words, then pulses done to start the engine.
module input_loader #(
    parameter int unsigned DATA_W    = lenet_pkg::DATA_W,
    parameter int unsigned ADDR_W    = lenet_pkg::ADDR_W,
    parameter int unsigned IMG_SZ    = lenet_pkg::IMG_SZ,
    parameter int unsigned PAD       = lenet_pkg::PAD,
    parameter int unsigned INPUT_SZ  = lenet_pkg::INPUT_SZ,
    parameter int unsigned PIX_W     = lenet_pkg::PIX_W,
    parameter int unsigned FRAC_BITS = lenet_pkg::FRAC_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              engine_busy,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    import lenet_pkg::*;

    localparam int unsigned CNT_W     = $clog2(INPUT_SZ);
    localparam int unsigned PIX_CNT_W = $clog2(IMG_SZ * IMG_SZ);
    localparam int unsigned Q_SHIFT   = FRAC_BITS - PIX_W;
    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(IMG_SZ * IMG_SZ - 1);

    loader_state_t         state_q;
    logic [PIX_CNT_W-1:0]  pix_q;
    logic                  frame_err_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_din_q;

    logic [CNT_W-1:0]      row;
    logic [CNT_W-1:0]      col;
    logic                  interior;
    logic                  last_pos;
    logic                  in_fill;
    logic                  handshake;
    logic                  advance;
    logic                  scan_clear;

    // Border positions advance every cycle; interior positions wait for a pixel.
    assign in_fill    = (state_q == LD_FILL);
    assign s_ready    = in_fill && interior;
    assign handshake  = s_ready && s_valid;
    assign advance    = in_fill && (!interior || s_valid);
    assign scan_clear = (state_q == LD_IDLE);

    pad_scan_counter #(
        .SZ     (INPUT_SZ),
        .BORDER (PAD),
        .IMG    (IMG_SZ),
        .CNT_W  (CNT_W)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .clear    (scan_clear),
        .advance  (advance),
        .row      (row),
        .col      (col),
        .interior (interior),
        .last_pos (last_pos)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LD_IDLE;
            pix_q       <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (load_start) begin
                        frame_err_q <= 1'b0;
                        pix_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= engine_busy ? LD_WAIT_ENG : LD_FILL;
                    end
                end
                LD_WAIT_ENG: begin
                    if (!engine_busy) begin
                        state_q <= LD_FILL;
                    end
                end
                LD_FILL: begin
                    if (advance) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= ADDR_W'(32'(row) * INPUT_SZ + 32'(col));
                        mem_din_q  <= interior ? (DATA_W'(s_data) << Q_SHIFT) : '0;
                        if (last_pos) begin
                            state_q <= LD_FINISH;
                        end
                    end
                    // s_last must coincide exactly with the final pixel of the frame.
                    if (handshake) begin
                        pix_q <= pix_q + PIX_CNT_W'(1);
                        if (s_last != (pix_q == LAST_PIX)) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                LD_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= LD_IDLE;
                end
                default: begin
                    state_q <= LD_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_din   = mem_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_input_loader.sv
// Directed bench for input_loader: builds an SRAM image from the write port and
// compares it, the write count and the done latency against hand-derived values.
module tb_input_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        engine_busy;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_din;
    logic        busy;
    logic        done;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall_cnt = 0;
    int lat       = -1;

    logic [31:0] mem [1024];
    int          hits [1024];
    int          wr_count = 0;
    int          done_seen = 0;
    int          wr_during_eng = 0;
    bit          first_wr_seen = 1'b0;
    logic        err_at_first_wr = 1'b0;

    input_loader dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .engine_busy (engine_busy),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_din     (mem_din),
        .busy        (busy),
        .done        (done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model; a fresh accepted load request starts a new image.
    always @(negedge clk) begin
        if (load_start && !busy) begin
            for (int a = 0; a < 1024; a++) begin
                mem[a]  = 32'hDEADBEEF;
                hits[a] = 0;
            end
            wr_count        = 0;
            done_seen       = 0;
            wr_during_eng   = 0;
            first_wr_seen   = 1'b0;
            err_at_first_wr = 1'b0;
        end
        if (mem_we) begin
            if (!first_wr_seen) begin
                err_at_first_wr = frame_err;
                first_wr_seen   = 1'b1;
            end
            mem[mem_addr]  = mem_din;
            hits[mem_addr] = hits[mem_addr] + 1;
            wr_count       = wr_count + 1;
            if (engine_busy) wr_during_eng = wr_during_eng + 1;
        end
        if (done) done_seen = done_seen + 1;
    end

    function automatic logic [31:0] exp_word(input int addr, input int mode);
        int r;
        int c;
        int p;
        r = addr / 32;
        c = addr % 32;
        if (r < 2 || r >= 30 || c < 2 || c >= 30) return 32'h0;
        p = (r - 2) * 28 + (c - 2);
        if (mode == 0) return 32'h0000FF00;
        return 32'((p % 256) << 8);
    endfunction

    function automatic int count_bad(input int mode);
        int bad;
        bad = 0;
        for (int a = 0; a < 1024; a++)
            if (hits[a] != 1 || mem[a] !== exp_word(a, mode)) bad++;
        return bad;
    endfunction

    task automatic send_frame(input int mode, input int gap_max, input int last_at, input int stop_at);
        int i;
        int gap;
        int guard;
        i = 0;
        gap = 0;
        guard = 0;
        while (i < stop_at && guard < 6000) begin
            @(posedge clk); #1;
            guard++;
            if (gap > 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                gap--;
            end else begin
                s_valid = 1'b1;
                s_data  = (mode == 0) ? 8'hFF : 8'(i % 256);
                s_last  = (i == last_at);
            end
            if (s_ready && !s_valid) stall_cnt++;
            if (s_ready && s_valid) begin
                i++;
                if (gap_max > 0) gap = int'($urandom_range(gap_max, 0));
            end
        end
        checks++;
        if (i != stop_at) begin
            failures++;
            $display("FAIL stream_accept: accepted %0d pixels, expected %0d", i, stop_at);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int gap_max, input int last_at,
                             input int eng_cycles, input bit second_start);
        stall_cnt = 0;
        lat = -1;
        fork
            send_frame(mode, gap_max, last_at, 784);
            begin
                int n;
                bit got;
                @(posedge clk); #1;
                load_start  = 1'b1;
                engine_busy = (eng_cycles > 0);
                @(posedge clk); #1;
                n = cyc;
                load_start = 1'b0;
                if (eng_cycles > 0) begin
                    repeat (eng_cycles - 1) @(posedge clk);
                    #1;
                    engine_busy = 1'b0;
                end
                if (second_start) begin
                    repeat (300) @(posedge clk);
                    #1;
                    load_start = 1'b1;
                    @(posedge clk); #1;
                    load_start = 1'b0;
                end
                got = 1'b0;
                for (int g = 0; g < 4000 && !got; g++) begin
                    @(negedge clk);
                    if (done) got = 1'b1;
                end
                checks++;
                if (!got) begin
                    failures++;
                    $display("FAIL done_timeout: done not seen within 4000 cycles");
                end else begin
                    lat = cyc - n;
                end
                repeat (2) @(negedge clk);
            end
        join
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load_start = 1'b0;
        engine_busy = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_we, busy, done, frame_err, s_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, expected 00000", {mem_we, busy, done, frame_err, s_ready});
        end
        checks++;
        if (mem_addr !== 10'd0 || mem_din !== 32'd0) begin
            failures++;
            $display("FAIL reset_bus: addr=%0d din=%h, expected 0/0", mem_addr, mem_din);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b we=%b, expected 0/0", busy, mem_we);
        end
    endtask

    task automatic test_all_ff;
        run_frame(0, 0, 783, 0, 1'b0);
        checks++;
        if (mem[0] !== 32'h0) begin failures++; $display("FAIL ff_addr0: got %h, expected 00000000", mem[0]); end
        checks++;
        if (mem[66] !== 32'h0000FF00) begin failures++; $display("FAIL ff_addr66: got %h, expected 0000ff00", mem[66]); end
        checks++;
        if (mem[1023] !== 32'h0) begin failures++; $display("FAIL ff_addr1023: got %h, expected 00000000", mem[1023]); end
        checks++;
        if (wr_count != 1024) begin failures++; $display("FAIL ff_writes: got %0d, expected 1024", wr_count); end
        checks++;
        if (lat != 1025) begin failures++; $display("FAIL ff_done_latency: got %0d edges, expected 1025", lat); end
        checks++;
        if (done_seen != 1) begin failures++; $display("FAIL ff_done_pulses: got %0d, expected 1", done_seen); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL ff_frame_err: got %b, expected 0", frame_err); end
        checks++;
        if (count_bad(0) != 0) begin failures++; $display("FAIL ff_image: %0d bad addresses, expected 0", count_bad(0)); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ff_busy_end: got %b, expected 0", busy); end
    endtask

    task automatic test_ramp;
        int border_ok;
        run_frame(1, 0, 783, 0, 1'b0);
        checks++;
        if (mem[66] !== 32'h0) begin failures++; $display("FAIL ramp_pix0: got %h, expected 00000000", mem[66]); end
        checks++;
        if (mem[93] !== 32'h00001B00) begin failures++; $display("FAIL ramp_pix27: got %h, expected 00001b00", mem[93]); end
        checks++;
        if (mem[98] !== 32'h00001C00) begin failures++; $display("FAIL ramp_pix28: got %h, expected 00001c00", mem[98]); end
        checks++;
        if (mem[957] !== 32'h00000F00) begin failures++; $display("FAIL ramp_pix783: got %h, expected 00000f00", mem[957]); end
        border_ok = 0;
        for (int a = 0; a < 1024; a++) begin
            int r;
            int c;
            r = a / 32;
            c = a % 32;
            if ((r < 2 || r >= 30 || c < 2 || c >= 30) && hits[a] == 1 && mem[a] === 32'h0) border_ok++;
        end
        checks++;
        if (border_ok != 240) begin failures++; $display("FAIL ramp_border: got %0d zero borders, expected 240", border_ok); end
        checks++;
        if (count_bad(1) != 0) begin failures++; $display("FAIL ramp_image: %0d bad addresses, expected 0", count_bad(1)); end
        checks++;
        if (lat != 1025) begin failures++; $display("FAIL ramp_done_latency: got %0d, expected 1025", lat); end
    endtask

    task automatic test_stalls;
        run_frame(1, 5, 783, 0, 1'b0);
        checks++;
        if (count_bad(1) != 0) begin failures++; $display("FAIL stall_image: %0d bad addresses, expected 0", count_bad(1)); end
        checks++;
        if (wr_count != 1024) begin failures++; $display("FAIL stall_writes: got %0d, expected 1024", wr_count); end
        checks++;
        if (stall_cnt == 0) begin failures++; $display("FAIL stall_count: got 0 stall cycles, expected >0"); end
        checks++;
        if (lat != 1025 + stall_cnt) begin
            failures++;
            $display("FAIL stall_done_latency: got %0d, expected %0d", lat, 1025 + stall_cnt);
        end
    endtask

    task automatic test_frame_err;
        run_frame(1, 0, 500, 0, 1'b0);
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL err_set: got %b, expected 1", frame_err); end
        checks++;
        if (wr_count != 1024 || done_seen != 1) begin
            failures++;
            $display("FAIL err_completes: writes=%0d done=%0d, expected 1024/1", wr_count, done_seen);
        end
        checks++;
        if (count_bad(1) != 0 || lat != 1025) begin
            failures++;
            $display("FAIL err_image: bad=%0d latency=%0d, expected 0/1025", count_bad(1), lat);
        end
        run_frame(1, 0, 783, 0, 1'b0);
        checks++;
        if (err_at_first_wr !== 1'b0) begin failures++; $display("FAIL err_cleared_on_start: got %b, expected 0", err_at_first_wr); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL err_clean_frame: got %b, expected 0", frame_err); end
    endtask

    task automatic test_engine_wait;
        run_frame(0, 0, 783, 20, 1'b1);
        checks++;
        if (wr_during_eng != 0) begin failures++; $display("FAIL eng_writes_while_busy: got %0d, expected 0", wr_during_eng); end
        checks++;
        if (lat != 1045) begin failures++; $display("FAIL eng_done_latency: got %0d, expected 1045", lat); end
        checks++;
        if (wr_count != 1024 || done_seen != 1) begin
            failures++;
            $display("FAIL eng_second_start: writes=%0d done=%0d, expected 1024/1", wr_count, done_seen);
        end
        checks++;
        if (count_bad(0) != 0) begin failures++; $display("FAIL eng_image: %0d bad addresses, expected 0", count_bad(0)); end
    endtask

    task automatic test_reset_mid_frame;
        int wr_before;
        stall_cnt = 0;
        fork
            send_frame(1, 0, 783, 300);
            begin
                @(posedge clk); #1;
                load_start = 1'b1;
                @(posedge clk); #1;
                load_start = 1'b0;
            end
        join
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_we, busy, done, frame_err, s_ready} !== 5'b0 || mem_addr !== 10'd0 || mem_din !== 32'd0) begin
            failures++;
            $display("FAIL midreset_outputs: flags=%b addr=%0d din=%h, expected all 0",
                     {mem_we, busy, done, frame_err, s_ready}, mem_addr, mem_din);
        end
        wr_before = wr_count;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wr_count != wr_before) begin
            failures++;
            $display("FAIL midreset_no_writes: got %0d writes, expected %0d", wr_count, wr_before);
        end
        run_frame(1, 0, 783, 0, 1'b0);
        checks++;
        if (count_bad(1) != 0) begin failures++; $display("FAIL midreset_image: %0d bad addresses, expected 0", count_bad(1)); end
        checks++;
        if (lat != 1025 || done_seen != 1) begin
            failures++;
            $display("FAIL midreset_done: latency=%0d done=%0d, expected 1025/1", lat, done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_all_ff();
        test_ramp();
        test_stalls();
        test_frame_err();
        test_engine_wait();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
